// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I memory-access stage: dmem req/gnt/rvalid handshake, lane steering, load extension
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_reg_write,
  input  logic              i_is_auipc,
  input  logic              i_is_lui,
  input  logic              i_jump,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_alu_result,
  input  logic [31:0]       i_store_data,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_pc_plus4,
  input  logic [31:0]       i_imm,
  input  logic [4:0]        i_rd,
  output logic              o_dmem_req,
  input  logic              i_dmem_gnt,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic              o_dmem_wen,
  output logic [3:0]        o_dmem_mask,
  output logic [31:0]       o_dmem_wdata,
  input  logic              i_dmem_rvalid,
  input  logic [31:0]       i_dmem_rdata,
  output logic              o_wb_valid,
  output logic              o_mem_read,
  output logic              o_reg_write,
  output logic              o_is_auipc,
  output logic              o_is_lui,
  output logic              o_jump,
  output logic [31:0]       o_mem_data_out,
  output logic [31:0]       o_alu_result,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_pc_plus4,
  output logic [31:0]       o_imm,
  output logic [4:0]        o_rd,
  output logic              o_trap
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        is_auipc;
    logic        is_lui;
    logic        jump;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imm;
    logic [4:0]  rd;
  } instr_t;

  state_t              state_q, state_d;
  instr_t              instr_q, instr_d, instr_in, src;
  logic                wb_valid_q, wb_valid_d;
  instr_t              out_q, out_d;
  logic [31:0]         mem_data_q, mem_data_d;
  logic                trap_q, trap_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [3:0]          mask_q, mask_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                is_mem, trap_in, complete, from_in;
  logic [31:0]         ld_data;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'b0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  assign instr_in = '{i_mem_read, i_mem_write, i_reg_write, i_is_auipc, i_is_lui, i_jump,
                      i_funct3, i_alu_result, i_pc, i_pc_plus4, i_imm, i_rd};
  assign is_mem = i_mem_read | i_mem_write;

  // Illegal encodings and misalignment are resolved at accept so no request is ever issued
  always_comb begin
    trap_in = 1'b0;
    if (i_mem_read && i_mem_write) trap_in = 1'b1;
    if (i_mem_read && (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111)) trap_in = 1'b1;
    if (i_mem_write && i_funct3 >= 3'b011) trap_in = 1'b1;
    if (i_mem_read && (i_funct3 == 3'b001 || i_funct3 == 3'b101) && i_alu_result[0]) trap_in = 1'b1;
    if (i_mem_write && i_funct3 == 3'b001 && i_alu_result[0]) trap_in = 1'b1;
    if (is_mem && i_funct3 == 3'b010 && i_alu_result[1:0] != 2'b00) trap_in = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    wb_valid_d = 1'b0;
    out_d      = out_q;
    mem_data_d = mem_data_q;
    trap_d     = trap_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    complete   = 1'b0;
    from_in    = 1'b0;
    ld_data    = 32'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          instr_d = instr_in;
          if (!is_mem || trap_in) begin
            complete = 1'b1;
            from_in  = 1'b1;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = ADDR_W'({i_alu_result[31:2], 2'b00});
            wen_d   = i_mem_write;
            mask_d  = 4'b1111;
            wdata_d = 32'b0;
            if (i_mem_write) begin
              case (i_funct3[1:0])
                2'b00: begin
                  mask_d  = 4'b0001 << i_alu_result[1:0];
                  wdata_d = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                  mask_d  = i_alu_result[1] ? 4'b1100 : 4'b0011;
                  wdata_d = {2{i_store_data[15:0]}};
                end
                default: wdata_d = i_store_data;
              endcase
            end
          end
        end
      end
      S_REQ: begin
        if (i_dmem_gnt) begin
          req_d = 1'b0;
          if (instr_q.mem_write) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end else if (i_dmem_rvalid) begin
            complete = 1'b1;
            ld_data  = load_ext(instr_q.funct3, instr_q.alu_result[1:0], i_dmem_rdata);
            state_d  = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_dmem_rvalid) begin
          complete = 1'b1;
          ld_data  = load_ext(instr_q.funct3, instr_q.alu_result[1:0], i_dmem_rdata);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    src = from_in ? instr_in : instr_q;
    if (complete) begin
      wb_valid_d          = 1'b1;
      out_d               = src;
      out_d.reg_write     = src.reg_write & ~(from_in & trap_in);
      trap_d              = from_in & trap_in;
      mem_data_d          = ld_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      wb_valid_q <= 1'b0;
      out_q      <= '0;
      mem_data_q <= 32'b0;
      trap_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      mask_q     <= 4'b0;
      wdata_q    <= 32'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      wb_valid_q <= wb_valid_d;
      out_q      <= out_d;
      mem_data_q <= mem_data_d;
      trap_q     <= trap_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
    end
  end

  assign o_ready        = (state_q == S_IDLE) & i_rst;
  assign o_dmem_req     = req_q;
  assign o_dmem_addr    = addr_q;
  assign o_dmem_wen     = wen_q;
  assign o_dmem_mask    = mask_q;
  assign o_dmem_wdata   = wdata_q;
  assign o_wb_valid     = wb_valid_q;
  assign o_mem_read     = out_q.mem_read;
  assign o_reg_write    = out_q.reg_write;
  assign o_is_auipc     = out_q.is_auipc;
  assign o_is_lui       = out_q.is_lui;
  assign o_jump         = out_q.jump;
  assign o_mem_data_out = mem_data_q;
  assign o_alu_result   = out_q.alu_result;
  assign o_pc           = out_q.pc;
  assign o_pc_plus4     = out_q.pc_plus4;
  assign o_imm          = out_q.imm;
  assign o_rd           = out_q.rd;
  assign o_trap         = trap_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_mem_read = 1'b0, i_mem_write = 1'b0, i_reg_write = 1'b0;
  logic        i_is_auipc = 1'b0, i_is_lui = 1'b0, i_jump = 1'b0;
  logic [2:0]  i_funct3 = 3'b0;
  logic [31:0] i_alu_result = 32'b0, i_store_data = 32'b0;
  logic [31:0] i_pc = 32'h100, i_pc_plus4 = 32'h104, i_imm = 32'h8;
  logic [4:0]  i_rd = 5'b0;
  logic        o_dmem_req;
  logic        i_dmem_gnt = 1'b0;
  logic [31:0] o_dmem_addr;
  logic        o_dmem_wen;
  logic [3:0]  o_dmem_mask;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_rvalid = 1'b0;
  logic [31:0] i_dmem_rdata = 32'b0;
  logic        o_wb_valid, o_mem_read, o_reg_write, o_is_auipc, o_is_lui, o_jump;
  logic [31:0] o_mem_data_out, o_alu_result, o_pc, o_pc_plus4, o_imm;
  logic [4:0]  o_rd;
  logic        o_trap;

  mem_access_stage #(.ADDR_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
    .i_is_auipc(i_is_auipc), .i_is_lui(i_is_lui), .i_jump(i_jump),
    .i_funct3(i_funct3), .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .i_pc(i_pc), .i_pc_plus4(i_pc_plus4), .i_imm(i_imm), .i_rd(i_rd),
    .o_dmem_req(o_dmem_req), .i_dmem_gnt(i_dmem_gnt), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wen(o_dmem_wen), .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_wb_valid(o_wb_valid), .o_mem_read(o_mem_read), .o_reg_write(o_reg_write),
    .o_is_auipc(o_is_auipc), .o_is_lui(o_is_lui), .o_jump(o_jump),
    .o_mem_data_out(o_mem_data_out), .o_alu_result(o_alu_result), .o_pc(o_pc),
    .o_pc_plus4(o_pc_plus4), .o_imm(o_imm), .o_rd(o_rd), .o_trap(o_trap)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] mdata;
    logic        trap;
    logic        rw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic req_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every writeback strobe must match the oldest outstanding expectation
  always @(negedge i_clk) begin
    if (o_dmem_req) req_seen = 1'b1;
    if (o_wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_alu_result", o_alu_result, e.alu);
        chk("wb_rd", {27'b0, o_rd}, {27'b0, e.rd});
        chk("wb_mem_data", o_mem_data_out, e.mdata);
        chk("wb_trap", {31'b0, o_trap}, {31'b0, e.trap});
        chk("wb_reg_write", {31'b0, o_reg_write}, {31'b0, e.rw});
      end
    end
  end

  task automatic drive_op(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
    i_valid      = 1'b1;
    i_mem_read   = mr;
    i_mem_write  = mw;
    i_reg_write  = rw;
    i_funct3     = f3;
    i_alu_result = alu;
    i_store_data = sd;
    i_rd         = rd;
  endtask

  task automatic push(input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] md,
                      input logic trap, input logic rw);
    exp_t e;
    e.alu = alu; e.rd = rd; e.mdata = md; e.trap = trap; e.rw = rw;
    exp_q.push_back(e);
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] expd, input int gap);
    drive_op(1'b1, 1'b0, 1'b1, f3, addr, 32'b0, 5'd7);
    push(addr, 5'd7, expd, 1'b0, 1'b1);
    step();
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("ld_req", {31'b0, o_dmem_req}, 32'd1);
    chk("ld_mask", {28'b0, o_dmem_mask}, 32'hF);
    chk("ld_addr", o_dmem_addr, {addr[31:2], 2'b00});
    chk("ld_wen", {31'b0, o_dmem_wen}, 32'd0);
    i_dmem_gnt = 1'b1;
    if (gap == 0) begin
      i_dmem_rvalid = 1'b1;
      i_dmem_rdata  = rdata;
    end
    step();
    i_dmem_gnt = 1'b0;
    i_dmem_rvalid = 1'b0;
    if (gap > 0) begin
      for (int k = 1; k < gap; k++) step();
      @(negedge i_clk);
      chk("wait_req_low", {31'b0, o_dmem_req}, 32'd0);
      chk("wait_ready_low", {31'b0, o_ready}, 32'd0);
      #1;
      i_dmem_rvalid = 1'b1;
      i_dmem_rdata  = rdata;
      step();
      i_dmem_rvalid = 1'b0;
    end
    @(negedge i_clk);
    chk("ld_wb_valid", {31'b0, o_wb_valid}, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", {31'b0, o_ready}, 32'd0);
    chk("rst_wb_valid", {31'b0, o_wb_valid}, 32'd0);
    chk("rst_req", {31'b0, o_dmem_req}, 32'd0);
    chk("rst_alu", o_alu_result, 32'd0);
    i_rst = 1'b1;
    #1;
    chk("ready_after_rst", {31'b0, o_ready}, 32'd1);

    // ALU ops: single then four back-to-back
    step();
    req_seen = 1'b0;
    drive_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h42, 32'b0, 5'd5);
    push(32'h42, 5'd5, 32'b0, 1'b0, 1'b1);
    step();
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("alu_wb_next_cycle", {31'b0, o_wb_valid}, 32'd1);
    step();
    for (int n = 0; n < 4; n++) begin
      drive_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h100 + n, 32'b0, 5'(n + 10));
      push(32'h100 + n, 5'(n + 10), 32'b0, 1'b0, 1'b1);
      step();
      if (n > 0) chk("b2b_wb_valid", {31'b0, o_wb_valid}, 32'd1);
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("b2b_last_wb_valid", {31'b0, o_wb_valid}, 32'd1);
    step();
    @(negedge i_clk);
    chk("alu_no_req", {31'b0, req_seen}, 32'd0);
    chk("alu_strobe_ends", {31'b0, o_wb_valid}, 32'd0);

    // SB with delayed grant
    step();
    drive_op(1'b0, 1'b1, 1'b0, 3'b000, 32'h1003, 32'h1234_56AB, 5'd0);
    push(32'h1003, 5'd0, 32'b0, 1'b0, 1'b0);
    step();
    i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) i_dmem_gnt = 1'b1;
      @(negedge i_clk);
      chk("sb_req", {31'b0, o_dmem_req}, 32'd1);
      chk("sb_addr", o_dmem_addr, 32'h1000);
      chk("sb_mask", {28'b0, o_dmem_mask}, 32'h8);
      chk("sb_wdata", o_dmem_wdata, 32'hABAB_ABAB);
      chk("sb_wen", {31'b0, o_dmem_wen}, 32'd1);
      chk("sb_ready", {31'b0, o_ready}, 32'd0);
      step();
    end
    i_dmem_gnt = 1'b0;
    @(negedge i_clk);
    chk("sb_req_drop", {31'b0, o_dmem_req}, 32'd0);
    chk("sb_wb_valid", {31'b0, o_wb_valid}, 32'd1);

    // SH upper half, immediate grant
    step();
    drive_op(1'b0, 1'b1, 1'b0, 3'b001, 32'h2002, 32'h1234_ABCD, 5'd0);
    push(32'h2002, 5'd0, 32'b0, 1'b0, 1'b0);
    step();
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("sh_mask", {28'b0, o_dmem_mask}, 32'hC);
    chk("sh_wdata", o_dmem_wdata, 32'hABCD_ABCD);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;

    // Spurious handshake signals in IDLE
    i_dmem_gnt = 1'b1;
    i_dmem_rvalid = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    i_dmem_rvalid = 1'b0;

    run_load(3'b000, 32'h2001, 32'h0000_8000, 32'hFFFF_FF80, 2);
    step();
    run_load(3'b100, 32'h2001, 32'h0000_8000, 32'h0000_0080, 2);
    step();
    run_load(3'b001, 32'h2002, 32'hBEEF_0000, 32'hFFFF_BEEF, 0);
    step();
    run_load(3'b010, 32'h2004, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);
    step();

    // Misaligned LW traps without a request
    req_seen = 1'b0;
    drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h3002, 32'b0, 5'd9);
    push(32'h3002, 5'd9, 32'b0, 1'b1, 1'b0);
    step();
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("trap_wb_valid", {31'b0, o_wb_valid}, 32'd1);
    step();
    @(negedge i_clk);
    chk("trap_no_req", {31'b0, req_seen}, 32'd0);

    // Reset while a load waits for data
    step();
    drive_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h4000, 32'b0, 5'd3);
    step();
    i_valid = 1'b0;
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_ready_low", {31'b0, o_ready}, 32'd0);
    step();
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_mid_req", {31'b0, o_dmem_req}, 32'd0);
    chk("rst_mid_alu", o_alu_result, 32'd0);
    chk("rst_mid_rd", {27'b0, o_rd}, 32'd0);
    chk("rst_mid_ready", {31'b0, o_ready}, 32'd1);
    #1;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'h1111_2222;
    step();
    i_dmem_rvalid = 1'b0;
    @(negedge i_clk);
    chk("late_rvalid_no_wb", {31'b0, o_wb_valid}, 32'd0);
    repeat (2) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage of the RV32I core. It sits between execute and writeback. It accepts one instruction at a time from execute, performs loads and stores on the data-memory port through a request/grant/response handshake, and aligns load data. It presents registered, writeback-ready results (data already extended, control pass-through) to the combinational writeback stage for exactly one cycle per instruction.

Parameters:
ADDR_W, 32, data-memory byte-address width; o_dmem_addr carries ADDR_W bits.

Ports:
i_clk  in  1  core clock
i_rst  in  1  reset; synchronous, active-low
i_valid  in  1  execute presents an instruction
o_ready  out  1  stage can accept (IDLE and not in reset)
i_mem_read, i_mem_write, i_reg_write, i_is_auipc, i_is_lui, i_jump  in  1 each  decoded controls
i_funct3  in  3  load/store size/sign
i_alu_result  in  32  effective address or ALU result
i_store_data  in  32  rs2 value
i_pc, i_pc_plus4, i_imm  in  32 each  pass-through
i_rd  in  5  destination register
o_dmem_req  out  1  memory request
i_dmem_gnt  in  1  request accepted
o_dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
o_dmem_wen  out  1  1=store
o_dmem_mask  out  4  byte enables
o_dmem_wdata  out  32  lane-replicated store data
i_dmem_rvalid  in  1  load data valid
i_dmem_rdata  in  32  load word
o_wb_valid  out  1  one-cycle result strobe to writeback
o_mem_read, o_reg_write, o_is_auipc, o_is_lui, o_jump  out  1 each  registered controls
o_mem_data_out  out  32  extended load data
o_alu_result, o_pc, o_pc_plus4, o_imm  out  32 each  registered pass-through
o_rd  out  5  registered destination
o_trap  out  1  misaligned or illegal access (valid with o_wb_valid)

Behaviour:
- One clock. Reset is synchronous and active-low on i_rst; the clock port is i_clk.
- Reset: state IDLE; every registered output is 0; o_ready is 0 while i_rst is low.
- Accept condition: i_valid & o_ready; all inputs are latched on that edge. o_ready = (state==IDLE) & i_rst.
- FSM states: IDLE, REQ, WAIT.
- IDLE, non-memory instruction: o_wb_valid=1 on the next cycle with latched values and o_mem_data_out=0. The FSM stays in IDLE, giving back-to-back throughput of 1 per cycle.
- IDLE, load/store: go to REQ. o_dmem_req=1 from the next cycle.
- Trap: go straight to o_wb_valid=1, o_trap=1, o_reg_write=0, with no dmem request. Trap conditions are:
  - mem_read & mem_write both set
  - load funct3 011/110/111
  - store funct3 >= 011
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]!=0
- REQ: o_dmem_req stays 1 and addr/wen/mask/wdata stay stable until i_dmem_gnt.
  - On gnt for a store: request drops next cycle, o_wb_valid=1 next cycle, return to IDLE.
  - On gnt for a load: go to WAIT. If i_dmem_rvalid is also high in the gnt cycle, complete the load as in WAIT.
  - i_dmem_rvalid without gnt in REQ is ignored.
- WAIT: on i_dmem_rvalid, capture the extended data; o_wb_valid=1 next cycle; return to IDLE.
- Latency from acceptance to o_wb_valid:
  - non-mem or trap: 1 cycle
  - store: gnt cycle + 1
  - load: rvalid cycle + 1
- o_wb_valid is a 1-cycle pulse. The other outputs hold their last values until the next completion.
- Store lane rules:
  - SB: mask = 1<<addr[1:0]; wdata = byte replicated x4.
  - SH: mask = 0011 if addr[1]=0, else 1100; wdata = halfword replicated x2.
  - SW: mask = 1111.
- Load lane rules: o_dmem_mask = 1111 and wen = 0 for all loads.
  - LB: byte at addr[1:0], sign-extended. LBU: same byte, zero-extended.
  - LH: halfword at addr[1], sign-extended. LHU: same halfword, zero-extended.
  - LW: full word.
- Spurious i_dmem_rvalid or i_dmem_gnt in IDLE is ignored.
- Reset mid-operation: state becomes IDLE and o_dmem_req falls at that edge. A late rvalid after reset produces no o_wb_valid.

Test Plan:
- ADD result 0x0000_0042, rd=5, no memory access → o_wb_valid on the next cycle with o_alu_result=0x42, o_rd=5, o_dmem_req never asserted. Four back-to-back ALU ops → four consecutive strobes.
- SB addr=0x1003, data=0x1234_56AB, gnt delayed 3 cycles → o_dmem_addr=0x1000, mask=1000, wdata=0xABABABAB, held stable until gnt; o_wb_valid at gnt+1; o_ready low throughout.
- LB addr=0x2001, rdata=0x0000_8000 returned 2 cycles after gnt → o_mem_data_out=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- LH addr=0x2002, rdata=0xBEEF_0000, with gnt and rvalid in the same cycle → o_mem_data_out=0xFFFF_BEEF, o_wb_valid on the next cycle.
- LW addr=0x3002 → no o_dmem_req; next cycle o_wb_valid=1, o_trap=1, o_reg_write=0.
- Load in WAIT, i_rst driven low for 1 cycle, then rvalid arrives → o_dmem_req and all outputs 0 after the reset edge; no o_wb_valid; o_ready=1 after reset is released.
